// File: rtl/parity_frame_rx_if.sv
// Bundles the serial line, per-frame parity select and the received-word
// report of the parity-framed serial receiver.
interface parity_frame_rx_if #(
  parameter int DATA_W = 4
);
  logic              rx;
  logic              odd_mode;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_error;
  logic              frame_error;
  logic              busy;

  modport master (
    output rx, odd_mode,
    input  data_out, data_valid, parity_error, frame_error, busy
  );

  modport slave (
    input  rx, odd_mode,
    output data_out, data_valid, parity_error, frame_error, busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial receiver for start / DATA_W data (LSB first) / parity / stop frames,
// reporting the word with parity and framing error flags.
module parity_frame_rx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_frame_rx_if.slave     bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_r;
  logic              sync1_r;
  logic              rx_s;
  logic [CW-1:0]     cnt_r;
  logic [BW-1:0]     bit_idx_r;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] msb_s;
  logic              mode_r;
  logic              par_bit_r;
  logic              stop_bit_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              parity_error_r;
  logic              frame_error_r;
  logic              busy_r;

  function automatic logic xor_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= bus.rx;
      rx_s    <= sync1_r;
    end
  end

  // Incoming bit lands in the MSB so that after DATA_W shifts the first bit is the LSB.
  always_comb begin
    msb_s             = '0;
    msb_s[DATA_W-1]   = rx_s;
  end

  // Frame FSM: mid-bit sampling, deserialisation and registered reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      bit_idx_r      <= '0;
      shreg_r        <= '0;
      mode_r         <= 1'b0;
      par_bit_r      <= 1'b0;
      stop_bit_r     <= 1'b0;
      data_out_r     <= '0;
      data_valid_r   <= 1'b0;
      parity_error_r <= 1'b0;
      frame_error_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (!rx_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (cnt_r == HALF_CNT) begin
            cnt_r <= '0;
            if (!rx_s) begin
              // Start confirmed; the parity sense is frozen for the whole frame here.
              mode_r    <= bus.odd_mode;
              bit_idx_r <= '0;
              state_r   <= DATA;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DATA: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r     <= '0;
            shreg_r   <= (shreg_r >> 1) | msb_s;
            bit_idx_r <= bit_idx_r + BW'(1);
            if (bit_idx_r == LAST_BIT) begin
              state_r <= PARITY;
            end else begin
              state_r <= DATA;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r     <= '0;
            par_bit_r <= rx_s;
            state_r   <= STOP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        STOP: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r      <= '0;
            stop_bit_r <= rx_s;
            state_r    <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          data_out_r     <= shreg_r;
          parity_error_r <= xor_parity(shreg_r) ^ par_bit_r ^ mode_r;
          frame_error_r  <= ~stop_bit_r;
          data_valid_r   <= 1'b1;
          busy_r         <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.parity_error = parity_error_r;
  assign bus.frame_error  = frame_error_r;
  assign bus.busy         = busy_r;
endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx (DATA_W=4, CLKS_PER_BIT=8) with
// hand-computed expected words, flags and latency.
module tb_parity_frame_rx;
  localparam int DW  = 4;
  localparam int CPB = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   start_cyc;
  int   vcount;
  int   busy_cycles;
  logic [DW-1:0] vdata [0:31];
  logic          vpe   [0:31];
  logic          vfe   [0:31];
  int            vcyc  [0:31];

  parity_frame_rx_if #(.DATA_W(DW)) bus ();

  parity_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every data_valid pulse and count busy cycles, sampled mid-period.
  always @(negedge clk) begin
    if (bus.busy) busy_cycles = busy_cycles + 1;
    if (bus.data_valid && vcount < 32) begin
      vdata[vcount] = bus.data_out;
      vpe[vcount]   = bus.parity_error;
      vfe[vcount]   = bus.frame_error;
      vcyc[vcount]  = cyc;
      vcount        = vcount + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // odd_mode is inverted right after the start bit; the DUT must ignore that.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input logic m);
    bus.odd_mode = m;
    start_cyc    = cyc;
    send_bit(1'b0);
    bus.odd_mode = ~m;
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    bus.rx = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int target);
    for (int i = 0; i < 200 && vcount < target; i++) begin
      @(posedge clk);
    end
    #1;
    check_eq(tag, vcount, target);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [DW-1:0] d,
                             input logic pe, input logic fe);
    check_eq({tag, "_data"}, vdata[idx], d);
    check_eq({tag, "_perr"}, vpe[idx], pe);
    check_eq({tag, "_ferr"}, vfe[idx], fe);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    vcount       = 0;
    busy_cycles  = 0;
    rst          = 1'b1;
    bus.rx       = 1'b1;
    bus.odd_mode = 1'b0;
    idle(3);
    check_eq("rst_data",  bus.data_out, 4'b0000);
    check_eq("rst_valid", bus.data_valid, 1'b0);
    check_eq("rst_perr",  bus.parity_error, 1'b0);
    check_eq("rst_ferr",  bus.frame_error, 1'b0);
    check_eq("rst_busy",  bus.busy, 1'b0);
    rst = 1'b0;
    idle(5);

    // 1: even, 1011 + p=1 -> four ones, no error.
    send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
    wait_valid("t1_count", 1);
    check_frame("t1", 0, 4'b1011, 1'b0, 1'b0);
    // rx_s goes low 2 edges after the drive edge, FSM reads it on the 3rd, then 53 more.
    check_eq("t1_latency", vcyc[0] - start_cyc, 56);
    idle(4);
    check_eq("t1_single_pulse", vcount, 1);

    // 2: odd, 0110 + p=1 -> three ones, ok; p=0 -> two ones, error.
    send_frame(4'b0110, 1'b1, 1'b1, 1'b1);
    wait_valid("t2a_count", 2);
    check_frame("t2a", 1, 4'b0110, 1'b0, 1'b0);
    idle(3);
    send_frame(4'b0110, 1'b0, 1'b1, 1'b1);
    wait_valid("t2b_count", 3);
    check_frame("t2b", 2, 4'b0110, 1'b1, 1'b0);
    idle(3);

    // 3: even, 1011 + p=0 -> three ones, error.
    send_frame(4'b1011, 1'b0, 1'b1, 1'b0);
    wait_valid("t3_count", 4);
    check_frame("t3", 3, 4'b1011, 1'b1, 1'b0);
    idle(3);

    // 4: stop=0 gives a framing error; a clean frame afterwards clears it.
    send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
    wait_valid("t4a_count", 5);
    check_frame("t4a", 4, 4'b1100, 1'b0, 1'b1);
    idle(CPB * 3);
    check_eq("t4_held_ferr", bus.frame_error, 1'b1);
    send_frame(4'b0101, 1'b0, 1'b1, 1'b0);
    wait_valid("t4b_count", 6);
    check_frame("t4b", 5, 4'b0101, 1'b0, 1'b0);
    idle(3);

    // 5: two-cycle glitch -> START for CPB/2 cycles, then back to IDLE.
    busy_cycles = 0;
    bus.rx = 1'b0;
    idle(2);
    bus.rx = 1'b1;
    idle(20);
    check_eq("t5_busy_cycles", busy_cycles, CPB / 2);
    check_eq("t5_no_valid", vcount, 6);
    check_eq("t5_idle", bus.busy, 1'b0);
    check_eq("t5_data_held", bus.data_out, 4'b0101);

    // 6: asynchronous reset in the middle of DATA.
    bus.odd_mode = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_data", bus.data_out, 4'b0000);
    check_eq("t6_rst_busy", bus.busy, 1'b0);
    check_eq("t6_rst_perr", bus.parity_error, 1'b0);
    check_eq("t6_rst_ferr", bus.frame_error, 1'b0);
    check_eq("t6_rst_valid", bus.data_valid, 1'b0);
    bus.rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(CPB * 8);
    check_eq("t6_aborted", vcount, 6);
    send_frame(4'b1100, 1'b0, 1'b1, 1'b0);
    send_frame(4'b1100, 1'b0, 1'b1, 1'b0);
    wait_valid("t6_b2b_count", 8);
    check_frame("t6a", 6, 4'b1100, 1'b0, 1'b0);
    check_frame("t6b", 7, 4'b1100, 1'b0, 1'b0);
    check_eq("t6_b2b_spacing", vcyc[7] - vcyc[6], CPB * (DW + 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
